// File: rtl/rst_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rst_pkg : shared types and entry-layout helpers for the register status  |
// |           table controller.                                              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package rst_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } rst_state_e;

    // Fill bit for the reserved "no producer" tag, which is all ones.
    localparam logic TAG_NULL_BIT = 1'b1;

    // The busy flag sits directly above the tag field of an entry.
    function automatic int unsigned busy_bit(input int unsigned w_tag);
        return w_tag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rst_ctrl : write-port arbiter, init/flush walker and decode read path    |
// |            for the register status table memory.                         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rst_ctrl
    import rst_pkg::*;
#(
    parameter int W_ADDR       = 5,
    parameter int W_TAG        = 6,
    parameter int INCLUDE_OREG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [W_ADDR-1:0] disp_rd,
    input  logic [W_TAG-1:0]  disp_tag,
    input  logic              cdb_valid,
    input  logic [W_TAG-1:0]  cdb_tag,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic              flush_done,
    input  logic              dec_valid,
    input  logic [W_ADDR-1:0] dec_rs_addr,
    input  logic [W_ADDR-1:0] dec_rt_addr,
    output logic              dec_rsp_valid,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [W_TAG-1:0]  rs_tag,
    output logic [W_TAG-1:0]  rt_tag,
    output logic [W_ADDR-1:0] rst_rport0_addr,
    output logic [W_ADDR-1:0] rst_rport1_addr,
    input  logic [W_TAG:0]    rst_rport0_data,
    input  logic [W_TAG:0]    rst_rport1_data,
    output logic [W_ADDR-1:0] rst_wport0_addr,
    output logic [W_ADDR-1:0] rst_wport1_addr,
    output logic [W_TAG:0]    rst_wport0_data,
    output logic [W_TAG:0]    rst_wport1_data,
    output logic              rst_wport0_wen,
    output logic              rst_wport1_wen,
    output logic [W_TAG-1:0]  rst_lookup_tag,
    input  logic              rst_lookup_found,
    input  logic [W_ADDR-1:0] rst_lookup_addr
);

    localparam int          W_DATA   = W_TAG + 1;
    localparam int          N_ENTRY  = 2 ** W_ADDR;
    localparam int          W_CNT    = (W_ADDR > 1) ? (W_ADDR - 1) : 1;
    localparam int unsigned BUSY_BIT = busy_bit(W_TAG);

    localparam logic [W_CNT-1:0]  C_CNT_LAST  = W_CNT'(N_ENTRY / 2 - 1);
    localparam logic [W_TAG-1:0]  C_TAG_NULL  = {W_TAG{TAG_NULL_BIT}};
    localparam logic [W_DATA-1:0] C_ENTRY_CLR = {1'b0, C_TAG_NULL};

    rst_state_e        r_state_q, w_state_d;
    logic [W_CNT-1:0]  r_cnt_q, w_cnt_d;
    logic              r_flush_done_q, w_flush_done_d;
    logic [W_ADDR-1:0] w_walk_addr0, w_walk_addr1;

    // Each walk step clears an even/odd pair, so the counter is half the index.
    assign w_walk_addr0 = W_ADDR'({r_cnt_q, 1'b0});
    assign w_walk_addr1 = w_walk_addr0 | W_ADDR'(1);

    assign disp_ready     = (r_state_q == ST_IDLE);
    assign flush_busy     = (r_state_q != ST_IDLE);
    assign flush_done     = r_flush_done_q;
    assign rst_lookup_tag = cdb_tag;

    always_comb begin
        w_state_d       = r_state_q;
        w_cnt_d         = r_cnt_q;
        w_flush_done_d  = 1'b0;
        rst_wport0_addr = w_walk_addr0;
        rst_wport1_addr = w_walk_addr1;
        rst_wport0_data = C_ENTRY_CLR;
        rst_wport1_data = C_ENTRY_CLR;
        rst_wport0_wen  = 1'b0;
        rst_wport1_wen  = 1'b0;
        case (r_state_q)
            ST_INIT, ST_FLUSH: begin
                rst_wport0_wen = 1'b1;
                rst_wport1_wen = 1'b1;
                w_cnt_d        = r_cnt_q + W_CNT'(1);
                if (r_cnt_q == C_CNT_LAST) begin
                    w_state_d      = ST_IDLE;
                    w_cnt_d        = '0;
                    w_flush_done_d = (r_state_q == ST_FLUSH);
                end
            end
            ST_IDLE: begin
                if (disp_valid) begin
                    rst_wport0_addr = disp_rd;
                    rst_wport0_data = {1'b1, disp_tag};
                    rst_wport0_wen  = 1'b1;
                end
                // A same-cycle dispatch to the completing register is the newer producer.
                if (cdb_valid && rst_lookup_found &&
                    !(disp_valid && (disp_rd == rst_lookup_addr))) begin
                    rst_wport1_addr = rst_lookup_addr;
                    rst_wport1_wen  = 1'b1;
                end
                if (flush_req) begin
                    w_state_d = ST_FLUSH;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = ST_INIT;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= ST_INIT;
            r_cnt_q        <= '0;
            r_flush_done_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_flush_done_q <= w_flush_done_d;
        end
    end

    assign rst_rport0_addr = dec_rs_addr;
    assign rst_rport1_addr = dec_rt_addr;
    assign rs_busy         = rst_rport0_data[BUSY_BIT];
    assign rt_busy         = rst_rport1_data[BUSY_BIT];
    assign rs_tag          = rst_rport0_data[W_TAG-1:0];
    assign rt_tag          = rst_rport1_data[W_TAG-1:0];

    generate
        if (INCLUDE_OREG != 0) begin : g_rsp_oreg
            logic r_rsp_valid_q, w_rsp_valid_d;
            assign w_rsp_valid_d = dec_valid;
            always_ff @(posedge clk) begin
                if (reset) r_rsp_valid_q <= 1'b0;
                else       r_rsp_valid_q <= w_rsp_valid_d;
            end
            assign dec_rsp_valid = r_rsp_valid_q;
        end else begin : g_rsp_comb
            assign dec_rsp_valid = dec_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rst_ctrl.sv
`default_nettype none
// tb_rst_ctrl : drives rst_ctrl against a behavioural table memory and checks
// decode responses and write-port activity against an abstract busy/tag table.
module tb_rst_ctrl;

    localparam int         W_ADDR  = 5;
    localparam int         W_TAG   = 6;
    localparam int         W_DATA  = 7;
    localparam int         N_ENTRY = 32;
    localparam int         N_WALK  = 16;
    localparam logic [5:0] TAG_NULL = 6'h3F;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              disp_valid = 1'b0, disp_ready;
    logic [W_ADDR-1:0] disp_rd = '0;
    logic [W_TAG-1:0]  disp_tag = '0;
    logic              cdb_valid = 1'b0;
    logic [W_TAG-1:0]  cdb_tag = '0;
    logic              flush_req = 1'b0, flush_busy, flush_done;
    logic              dec_valid = 1'b0, dec_rsp_valid;
    logic [W_ADDR-1:0] dec_rs_addr = '0, dec_rt_addr = '0;
    logic              rs_busy, rt_busy;
    logic [W_TAG-1:0]  rs_tag, rt_tag;
    logic [W_ADDR-1:0] rport0_addr, rport1_addr, wport0_addr, wport1_addr;
    logic [W_DATA-1:0] rport0_data, rport1_data, wport0_data, wport1_data;
    logic              wport0_wen, wport1_wen;
    logic [W_TAG-1:0]  lookup_tag;
    logic              lookup_found;
    logic [W_ADDR-1:0] lookup_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Environment: table memory with registered reads, zero on reset, tag CAM.
    logic [W_DATA-1:0] mem [N_ENTRY];

    // Reference model: abstract busy/tag view of every architectural register.
    logic              ref_busy [N_ENTRY];
    logic [W_TAG-1:0]  ref_tag  [N_ENTRY];

    rst_ctrl #(.W_ADDR(W_ADDR), .W_TAG(W_TAG), .INCLUDE_OREG(1)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_rd(disp_rd), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .dec_valid(dec_valid), .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr),
        .dec_rsp_valid(dec_rsp_valid),
        .rs_busy(rs_busy), .rt_busy(rt_busy), .rs_tag(rs_tag), .rt_tag(rt_tag),
        .rst_rport0_addr(rport0_addr), .rst_rport1_addr(rport1_addr),
        .rst_rport0_data(rport0_data), .rst_rport1_data(rport1_data),
        .rst_wport0_addr(wport0_addr), .rst_wport1_addr(wport1_addr),
        .rst_wport0_data(wport0_data), .rst_wport1_data(wport1_data),
        .rst_wport0_wen(wport0_wen), .rst_wport1_wen(wport1_wen),
        .rst_lookup_tag(lookup_tag), .rst_lookup_found(lookup_found),
        .rst_lookup_addr(lookup_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRY; i++) mem[i] <= '0;
        end else begin
            if (wport0_wen) mem[wport0_addr] <= wport0_data;
            if (wport1_wen) mem[wport1_addr] <= wport1_data;
        end
        rport0_data <= mem[rport0_addr];
        rport1_data <= mem[rport1_addr];
    end

    always_comb begin
        lookup_found = 1'b0;
        lookup_addr  = '0;
        for (int i = N_ENTRY - 1; i >= 0; i--) begin
            if (mem[i][W_TAG-1:0] == lookup_tag) begin
                lookup_found = 1'b1;
                lookup_addr  = W_ADDR'(i);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_clear_all();
        for (int i = 0; i < N_ENTRY; i++) begin
            ref_busy[i] = 1'b0;
            ref_tag[i]  = TAG_NULL;
        end
    endtask

    function automatic int find_live(input logic [W_TAG-1:0] t);
        for (int i = 0; i < N_ENTRY; i++)
            if (ref_busy[i] && ref_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic logic [W_TAG-1:0] pick_free_tag();
        int base;
        base = int'($urandom_range(0, 62));
        for (int k = 0; k < 63; k++)
            if (find_live(W_TAG'((base + k) % 63)) < 0) return W_TAG'((base + k) % 63);
        return 6'h00;
    endfunction

    task automatic rd_chk(input logic [W_ADDR-1:0] a, input logic [W_ADDR-1:0] b);
        dec_valid   = 1'b1;
        dec_rs_addr = a;
        dec_rt_addr = b;
        tick();
        dec_valid = 1'b0;
        chk("rsp_valid", 32'(dec_rsp_valid), 32'd1);
        chk("rs_busy", 32'(rs_busy), 32'(ref_busy[a]));
        chk("rs_tag", 32'(rs_tag), 32'(ref_tag[a]));
        chk("rt_busy", 32'(rt_busy), 32'(ref_busy[b]));
        chk("rt_tag", 32'(rt_tag), 32'(ref_tag[b]));
    endtask

    task automatic rd_all();
        for (int i = 0; i < N_ENTRY / 2; i++)
            rd_chk(W_ADDR'(2 * i), W_ADDR'(2 * i + 1));
    endtask

    task automatic walk_chk(input string tag);
        for (int c = 0; c < N_WALK; c++) begin
            chk({tag, "_busy"}, 32'(flush_busy), 32'd1);
            chk({tag, "_ready"}, 32'(disp_ready), 32'd0);
            chk({tag, "_done"}, 32'(flush_done), 32'd0);
            chk({tag, "_w0addr"}, 32'(wport0_addr), 32'(2 * c));
            chk({tag, "_w1addr"}, 32'(wport1_addr), 32'(2 * c + 1));
            chk({tag, "_wen"}, 32'({wport0_wen, wport1_wen}), 32'd3);
            chk({tag, "_w0data"}, 32'(wport0_data), 32'h3F);
            chk({tag, "_w1data"}, 32'(wport1_data), 32'h3F);
            flush_req = (c >= 2 && c <= 13);
            tick();
        end
        flush_req = 1'b0;
    endtask

    initial begin
        logic             do_disp, do_cdb, exp_w1, e_rs_b, e_rt_b;
        logic [W_ADDR-1:0] rd, ra, rb;
        logic [W_TAG-1:0]  dt, ct, e_rs_t, e_rt_t;
        int               hit, k;

        ref_clear_all();
        tick();
        tick();
        chk("rst_busy", 32'(flush_busy), 32'd1);
        chk("rst_ready", 32'(disp_ready), 32'd0);
        chk("rst_done", 32'(flush_done), 32'd0);
        chk("rst_rspv", 32'(dec_rsp_valid), 32'd0);

        reset = 1'b0;
        walk_chk("init");
        chk("init_end_ready", 32'(disp_ready), 32'd1);
        chk("init_end_busy", 32'(flush_busy), 32'd0);
        chk("init_no_done", 32'(flush_done), 32'd0);
        rd_all();

        cdb_valid = 1'b1;
        cdb_tag   = 6'h00;
        #1;
        chk("tag0_found", 32'(lookup_found), 32'd0);
        chk("tag0_wen1", 32'(wport1_wen), 32'd0);
        tick();
        cdb_valid = 1'b0;

        disp_valid = 1'b1; disp_rd = 5'd5; disp_tag = 6'h0A;
        #1;
        chk("disp_wen0", 32'(wport0_wen), 32'd1);
        chk("disp_addr0", 32'(wport0_addr), 32'd5);
        chk("disp_data0", 32'(wport0_data), 32'h4A);
        tick();
        disp_valid = 1'b0;
        ref_busy[5] = 1'b1; ref_tag[5] = 6'h0A;
        dec_valid = 1'b1; dec_rs_addr = 5'd5; dec_rt_addr = 5'd0;
        #1;
        chk("rspv_latency", 32'(dec_rsp_valid), 32'd0);
        tick();
        dec_valid = 1'b0;
        chk("r5_rspv", 32'(dec_rsp_valid), 32'd1);
        chk("r5_busy", 32'(rs_busy), 32'd1);
        chk("r5_tag", 32'(rs_tag), 32'h0A);

        cdb_valid = 1'b1; cdb_tag = 6'h0A;
        #1;
        chk("cdb_lookup_tag", 32'(lookup_tag), 32'h0A);
        chk("cdb_wen1", 32'(wport1_wen), 32'd1);
        chk("cdb_addr1", 32'(wport1_addr), 32'd5);
        chk("cdb_data1", 32'(wport1_data), 32'h3F);
        tick();
        ref_busy[5] = 1'b0; ref_tag[5] = TAG_NULL;
        cdb_tag = 6'h11;
        #1;
        chk("cdb_miss_wen1", 32'(wport1_wen), 32'd0);
        tick();
        cdb_valid = 1'b0;
        rd_chk(5'd5, 5'd4);

        disp_valid = 1'b1; disp_rd = 5'd5; disp_tag = 6'h0A;
        tick();
        disp_tag = 6'h0B; cdb_valid = 1'b1; cdb_tag = 6'h0A;
        #1;
        chk("coll_wen0", 32'(wport0_wen), 32'd1);
        chk("coll_wen1", 32'(wport1_wen), 32'd0);
        tick();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        ref_busy[5] = 1'b1; ref_tag[5] = 6'h0B;
        rd_chk(5'd5, 5'd6);

        for (int it = 0; it < 300; it++) begin
            do_disp = 1'($urandom_range(0, 1));
            do_cdb  = 1'($urandom_range(0, 1));
            rd = W_ADDR'($urandom_range(0, 31));
            ra = W_ADDR'($urandom_range(0, 31));
            rb = W_ADDR'($urandom_range(0, 31));
            dt = pick_free_tag();
            k  = int'($urandom_range(0, 31));
            ct = ref_busy[k] ? ref_tag[k] : W_TAG'($urandom_range(0, 62));
            hit = do_cdb ? find_live(ct) : -1;
            exp_w1 = (hit >= 0) && !(do_disp && rd == W_ADDR'(hit));
            e_rs_b = ref_busy[ra]; e_rs_t = ref_tag[ra];
            e_rt_b = ref_busy[rb]; e_rt_t = ref_tag[rb];
            disp_valid = do_disp; disp_rd = rd; disp_tag = dt;
            cdb_valid = do_cdb; cdb_tag = ct;
            dec_valid = 1'b1; dec_rs_addr = ra; dec_rt_addr = rb;
            #1;
            chk("rnd_ready", 32'(disp_ready), 32'd1);
            chk("rnd_wen1", 32'(wport1_wen), 32'(exp_w1));
            if (exp_w1) chk("rnd_addr1", 32'(wport1_addr), 32'(hit));
            tick();
            chk("rnd_rs", 32'({e_rs_b, e_rs_t}), 32'({rs_busy, rs_tag}));
            chk("rnd_rt", 32'({e_rt_b, e_rt_t}), 32'({rt_busy, rt_tag}));
            if (exp_w1) begin
                ref_busy[hit] = 1'b0; ref_tag[hit] = TAG_NULL;
            end
            if (do_disp) begin
                ref_busy[rd] = 1'b1; ref_tag[rd] = dt;
            end
        end
        disp_valid = 1'b0; cdb_valid = 1'b0; dec_valid = 1'b0;
        tick();
        rd_all();

        disp_valid = 1'b1; disp_rd = 5'd3; disp_tag = pick_free_tag();
        ref_busy[3] = 1'b1; ref_tag[3] = disp_tag;
        tick();
        disp_rd = 5'd7; disp_tag = pick_free_tag();
        ref_busy[7] = 1'b1; ref_tag[7] = disp_tag;
        tick();
        disp_valid = 1'b0;
        rd_chk(5'd3, 5'd7);

        disp_valid = 1'b1; disp_rd = 5'd9; disp_tag = pick_free_tag(); flush_req = 1'b1;
        #1;
        chk("flreq_wen0", 32'(wport0_wen), 32'd1);
        chk("flreq_addr0", 32'(wport0_addr), 32'd9);
        tick();
        flush_req = 1'b0;
        disp_rd = 5'd4; disp_tag = 6'h21; cdb_valid = 1'b1; cdb_tag = ref_tag[3];
        walk_chk("flush");
        disp_valid = 1'b0; cdb_valid = 1'b0;
        #1;
        chk("flush_end_busy", 32'(flush_busy), 32'd0);
        chk("flush_done_pulse", 32'(flush_done), 32'd1);
        chk("flush_end_ready", 32'(disp_ready), 32'd1);
        tick();
        chk("flush_done_once", 32'(flush_done), 32'd0);
        ref_clear_all();
        rd_all();

        disp_valid = 1'b1; disp_rd = 5'd12; disp_tag = 6'h05;
        tick();
        disp_valid = 1'b0; flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("mid_flush_addr0", 32'(wport0_addr), 32'd12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        walk_chk("reinit");
        chk("reinit_end_busy", 32'(flush_busy), 32'd0);
        chk("reinit_no_done", 32'(flush_done), 32'd0);
        chk("reinit_ready", 32'(disp_ready), 32'd1);
        tick();
        chk("reinit_no_done2", 32'(flush_done), 32'd0);
        ref_clear_all();
        rd_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rst_ctrl.md
Name: rst_ctrl

Overview:
- Controller that sequences the register status table (RST) memory: {busy, tag} per architectural register.
- Arbitrates the table's two write ports between dispatch (mark rd busy with new tag) and CDB completion (clear the matching entry).
- Performs the post-reset init walk and the mispredict flush walk.
- Converts decode source-register reads into busy/tag responses, aligned to the memory's output-register latency.

Parameters:
- W_ADDR, 5, architectural register index width; N_ENTRY = 2**W_ADDR; W_ADDR >= 1.
- W_TAG, 6, ROB tag width; entry width W_DATA = W_TAG+1, derived locally.
- INCLUDE_OREG, 1, must equal the RST memory instance setting; read-response latency in cycles (0 or 1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  dispatch accepted when valid&&ready.
- disp_rd  in  W_ADDR  destination register.
- disp_tag  in  W_TAG  new producer tag; never TAG_NULL.
- cdb_valid  in  1  completion broadcast.
- cdb_tag  in  W_TAG  completing tag.
- flush_req  in  1  squash all busy state.
- flush_busy  out  1  init or flush walk in progress.
- flush_done  out  1  one-cycle pulse at flush completion.
- dec_valid  in  1  decode read request.
- dec_rs_addr, dec_rt_addr  in  W_ADDR  source registers.
- dec_rsp_valid  out  1  response valid.
- rs_busy, rt_busy  out  1  entry busy bits.
- rs_tag, rt_tag  out  W_TAG  entry tags.
- rst_rport0_addr, rst_rport1_addr  out  W_ADDR  to memory.
- rst_rport0_data, rst_rport1_data  in  W_DATA  from memory.
- rst_wport0_addr, rst_wport1_addr  out  W_ADDR.
- rst_wport0_data, rst_wport1_data  out  W_DATA.
- rst_wport0_wen, rst_wport1_wen  out  1.
- rst_lookup_tag  out  W_TAG.
- rst_lookup_found  in  1.
- rst_lookup_addr  in  W_ADDR.

Behaviour:
- Entry format: bit W_TAG = busy, bits [W_TAG-1:0] = tag. Cleared entry = {1'b0, TAG_NULL}, TAG_NULL = all ones.
- Memory reset leaves entries at zero, which would match tag 0. The init walk is therefore mandatory.
- FSM states: INIT, IDLE, FLUSH.
  - Reset: state=INIT, walk counter=0, flush_done=0, dec_rsp_valid=0 (when INCLUDE_OREG=1).
  - First cycle with reset low is cycle 0.
- INIT and FLUSH walk:
  - Per cycle, wport0 writes addr 2*cnt and wport1 writes addr 2*cnt+1, both with the cleared value; cnt increments.
  - Walk lasts N_ENTRY/2 cycles, then state goes to IDLE.
  - Default config: INIT occupies cycles 0..15; IDLE from cycle 16.
- flush_busy = (state != IDLE).
- flush_done: registered; pulses in the first IDLE cycle after a FLUSH walk only, never after INIT.
- disp_ready = (state == IDLE), combinational.
- IDLE, accepted dispatch: wport0 writes {1, disp_tag} to disp_rd in the same cycle; visible in the table next cycle.
- IDLE, cdb_valid: rst_lookup_tag = cdb_tag combinationally.
  - If found, wport1 writes the cleared value to rst_lookup_addr in the same cycle.
  - Not found (tag superseded or never mapped): no write.
- Dispatch and CDB clear to the same address in one cycle: CDB write suppressed; the newer producer wins. The two ports never write the same address.
- In INIT/FLUSH, dispatch is stalled and cdb_valid is ignored (dropped).
- flush_req:
  - Sampled only in IDLE; a dispatch accepted in the same cycle still writes; FLUSH starts next cycle.
  - Ignored in INIT/FLUSH.
- Reset mid-walk or mid-operation: return to INIT, cnt=0, walk restarts.
- Reads:
  - rst_rport0_addr = dec_rs_addr, rst_rport1_addr = dec_rt_addr, always.
  - Busy/tag fields are sliced from the port data.
  - dec_rsp_valid = dec_valid delayed INCLUDE_OREG cycles.
  - A response reflects table state at the start of the request cycle; same-cycle writes are not forwarded.
  - Requests are served in every state; decode must stall while flush_busy is high.
- Tag-uniqueness invariant: at most one entry matches any tag other than TAG_NULL.

Decomposition:
- Package rst_pkg: TAG_NULL, BUSY_BIT index, entry-field helper functions, FSM state enum {INIT, IDLE, FLUSH}.
- No sub-module. rst_ctrl and the RST memory are instantiated side by side in a thin top, rst_unit.

Test Plan:
- Reset 2 cycles then release -> disp_ready low cycles 0..15, high at 16; every entry reads busy=0, tag=0x3F; no lookup of tag 0 matches.
- Dispatch rd=5 tag=0x0A, then dec_rs_addr=5 next cycle -> rs_busy=1, rs_tag=0x0A, with dec_rsp_valid one cycle after dec_valid (INCLUDE_OREG=1).
- CDB tag=0x0A with r5 holding 0x0A -> next-cycle read r5 gives busy=0, tag=0x3F; CDB tag=0x11 with no match -> no write enable.
- Same cycle: dispatch r5 tag=0x0B and CDB tag=0x0A (r5 holds 0x0A) -> r5={1,0x0B}; wport1_wen=0; no same-address double write.
- r3, r7 busy; flush_req in IDLE -> flush_busy high 16 cycles, CDB and dispatch during the walk ignored, flush_done pulses once, all entries cleared.
- Reset asserted at walk cycle 6 of FLUSH -> INIT restarts from cnt=0; 16 cycles later IDLE with all entries cleared; no flush_done.
